truth_table_scanner: RTL and testbench

TRUTH_TABLE_SCANNER -- requirements
Module: truth_table_scanner

---
 rtl/truth_table_scanner_pkg.sv | 41 ++++
 rtl/truth_table_scanner_ff_eval.sv | 17 +
 rtl/truth_table_scanner.sv | 149 ++++++++++++++
 tb/tb_truth_table_scanner.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/truth_table_scanner_pkg.sv
// Shared types and constants for the truth-table scanner.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package truth_table_scanner_pkg;

    localparam int TT_WIDTH  = 16;
    localparam int IDX_WIDTH = 4;

    // Reference truth table of the evaluated function (ones at 7,9,10,11,13,14)
    localparam logic [TT_WIDTH-1:0] FF_TRUTH = 16'h6E80;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Index of the lowest set bit; 0 when no bit is set
    function automatic logic [IDX_WIDTH-1:0] lowest_set(input logic [TT_WIDTH-1:0] v);
        logic [IDX_WIDTH-1:0] idx;
        idx = '0;
        for (int i = TT_WIDTH - 1; i >= 0; i--) begin
            if (v[i]) idx = IDX_WIDTH'(i);
        end
        return idx;
    endfunction

`ifdef MINTERM_COUNT_EN
    // Number of set bits in a truth table
    function automatic logic [IDX_WIDTH:0] popcount(input logic [TT_WIDTH-1:0] v);
        logic [IDX_WIDTH:0] cnt;
        cnt = '0;
        for (int i = 0; i < TT_WIDTH; i++) begin
            cnt = cnt + (IDX_WIDTH + 1)'(v[i]);
        end
        return cnt;
    endfunction
`endif

endpackage

// File: rtl/truth_table_scanner_ff_eval.sv
// Combinational four-input function under test: s = f(a,b,c,d), a is the MSB.
// Latency: zero cycles (pure combinational).
// Backpressure: none.
module ff_eval (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    input  logic i_d,
    output logic o_s
);

    assign o_s = (~i_a &  i_b &  i_c &  i_d) |
                 ( i_a & ~i_c &  i_d)        |
                 ( i_a &  i_c & ~i_d)        |
                 ( i_a &  i_d & ~i_b);

endmodule

// File: rtl/truth_table_scanner.sv
// Walks all 16 minterms through ff_eval, captures the truth table and compares it to a reference.
// Latency: done pulses 16*STEP_CYCLES+2 cycles after the start-sampling edge.
// Backpressure: none; start is ignored while busy or in DONE. Optional MINTERM_COUNT_EN adds o_ones_cnt.
module truth_table_scanner
    import truth_table_scanner_pkg::*;
#(
    parameter int unsigned STEP_CYCLES = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic                 i_abort,
    input  logic [TT_WIDTH-1:0]  i_expected,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [TT_WIDTH-1:0]  o_table,
    output logic                 o_pass,
    output logic                 o_mism_valid,
    output logic [IDX_WIDTH-1:0] o_mism_idx,
`ifdef MINTERM_COUNT_EN
    output logic [IDX_WIDTH-1:0] o_cur_idx,
    output logic [IDX_WIDTH:0]   o_ones_cnt
`else
    output logic [IDX_WIDTH-1:0] o_cur_idx
`endif
);

    // Last hold-counter value for a minterm; the counter is 4 bits wide (STEP_CYCLES <= 15)
    localparam logic [3:0] HOLD_LAST = 4'(STEP_CYCLES - 1);

    state_t               r_state;
    logic [IDX_WIDTH-1:0] r_cur_idx;
    logic [3:0]           r_hold;
    logic [TT_WIDTH-1:0]  r_table;
    logic [TT_WIDTH-1:0]  r_exp;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_pass;
    logic                 r_mism_valid;
    logic [IDX_WIDTH-1:0] r_mism_idx;

    logic                 w_s;
    logic [TT_WIDTH-1:0]  w_diff;

    assign w_diff = r_table ^ r_exp;

    ff_eval u_ff_eval (
        .i_a (r_cur_idx[3]),
        .i_b (r_cur_idx[2]),
        .i_c (r_cur_idx[1]),
        .i_d (r_cur_idx[0]),
        .o_s (w_s)
    );

    // Scan FSM: sequence minterms, capture results, compare, pulse done
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_cur_idx    <= '0;
            r_hold       <= '0;
            r_table      <= '0;
            r_exp        <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_mism_valid <= 1'b0;
            r_mism_idx   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // start wins over a simultaneous abort; abort alone does nothing here
                    if (i_start) begin
                        r_state      <= ST_SCAN;
                        r_busy       <= 1'b1;
                        r_cur_idx    <= '0;
                        r_hold       <= '0;
                        r_table      <= '0;
                        r_pass       <= 1'b0;
                        r_mism_valid <= 1'b0;
                        r_mism_idx   <= '0;
                        r_exp        <= i_expected;
                    end
                end
                ST_SCAN: begin
                    if (i_abort) begin
                        // Partial table is kept; pass/mism were cleared when the scan started
                        r_state   <= ST_IDLE;
                        r_busy    <= 1'b0;
                        r_cur_idx <= '0;
                        r_hold    <= '0;
                    end else if (r_hold == HOLD_LAST) begin
                        r_table[r_cur_idx] <= w_s;
                        r_hold             <= '0;
                        r_cur_idx          <= r_cur_idx + 4'd1;
                        if (r_cur_idx == 4'd15) begin
                            r_state <= ST_CHECK;
                        end
                    end else begin
                        r_hold <= r_hold + 4'd1;
                    end
                end
                ST_CHECK: begin
                    r_busy <= 1'b0;
                    if (i_abort) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_pass       <= (w_diff == '0);
                        r_mism_valid <= |w_diff;
                        r_mism_idx   <= lowest_set(w_diff);
                        r_state      <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef MINTERM_COUNT_EN
    logic [IDX_WIDTH:0] r_ones_cnt;

    // Ones count of the captured table, refreshed with the comparison results
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ones_cnt <= '0;
        end else if (r_state == ST_CHECK && !i_abort) begin
            r_ones_cnt <= popcount(r_table);
        end
    end

    assign o_ones_cnt = r_ones_cnt;
`endif

    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_table      = r_table;
    assign o_pass       = r_pass;
    assign o_mism_valid = r_mism_valid;
    assign o_mism_idx   = r_mism_idx;
    assign o_cur_idx    = r_cur_idx;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Directed bench for truth_table_scanner: one instance with STEP_CYCLES=1, one with STEP_CYCLES=3.
// Expected values are hand-derived from the function's truth table 16'h6E80.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_truth_table_scanner;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        a_start, a_abort;
    logic [15:0] a_exp;
    logic        a_busy, a_done, a_pass, a_mv;
    logic [15:0] a_table;
    logic [3:0]  a_midx, a_cur;

    logic        b_start, b_abort;
    logic [15:0] b_exp;
    logic        b_busy, b_done, b_pass, b_mv;
    logic [15:0] b_table;
    logic [3:0]  b_midx, b_cur;

`ifdef MINTERM_COUNT_EN
    logic [4:0]  a_ones, b_ones;
`endif

    int n_err = 0;
    int n_chk = 0;

    always #5 clk = ~clk;

    truth_table_scanner #(.STEP_CYCLES(1)) u_dut_a (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (a_start),
        .i_abort      (a_abort),
        .i_expected   (a_exp),
        .o_busy       (a_busy),
        .o_done       (a_done),
        .o_table      (a_table),
        .o_pass       (a_pass),
        .o_mism_valid (a_mv),
        .o_mism_idx   (a_midx),
`ifdef MINTERM_COUNT_EN
        .o_cur_idx    (a_cur),
        .o_ones_cnt   (a_ones)
`else
        .o_cur_idx    (a_cur)
`endif
    );

    truth_table_scanner #(.STEP_CYCLES(3)) u_dut_b (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (b_start),
        .i_abort      (b_abort),
        .i_expected   (b_exp),
        .o_busy       (b_busy),
        .o_done       (b_done),
        .o_table      (b_table),
        .o_pass       (b_pass),
        .o_mism_valid (b_mv),
        .o_mism_idx   (b_midx),
`ifdef MINTERM_COUNT_EN
        .o_cur_idx    (b_cur),
        .o_ones_cnt   (b_ones)
`else
        .o_cur_idx    (b_cur)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start on instance A and count cycles until done (bounded)
    task automatic run_a(input logic [15:0] exp, input logic with_abort, output int lat);
        a_exp   = exp;
        a_start = 1'b1;
        a_abort = with_abort;
        tick();
        a_start = 1'b0;
        a_abort = 1'b0;
        lat = 0;
        while (!a_done && lat < 200) begin
            tick();
            lat++;
        end
    endtask

    initial begin
        int lat;
        int dones;

        rst_n   = 1'b0;
        a_start = 1'b0; a_abort = 1'b0; a_exp = 16'h0;
        b_start = 1'b0; b_abort = 1'b0; b_exp = 16'h0;
        #1;
        check("rst_busy",  32'(a_busy),  32'd0);
        check("rst_done",  32'(a_done),  32'd0);
        check("rst_table", 32'(a_table), 32'd0);
        check("rst_pass",  32'(a_pass),  32'd0);
        check("rst_mv",    32'(a_mv),    32'd0);
        check("rst_midx",  32'(a_midx),  32'd0);
        check("rst_cur",   32'(a_cur),   32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Matching reference: 18-cycle latency, clean pass
        run_a(16'h6E80, 1'b0, lat);
        check("match_lat",   32'(lat),     32'd18);
        check("match_table", 32'(a_table), 32'h6E80);
        check("match_pass",  32'(a_pass),  32'd1);
        check("match_mv",    32'(a_mv),    32'd0);
        check("match_midx",  32'(a_midx),  32'd0);
        check("match_busy",  32'(a_busy),  32'd0);
        check("match_cur",   32'(a_cur),   32'd0);
`ifdef MINTERM_COUNT_EN
        check("ones_cnt",    32'(a_ones),  32'd6);
`endif
        tick();
        check("done_one_cycle", 32'(a_done), 32'd0);
        repeat (4) tick();
        check("hold_table", 32'(a_table), 32'h6E80);
        check("hold_pass",  32'(a_pass),  32'd1);

        // Reference missing bit 7: lowest mismatch is 7
        run_a(16'h6E00, 1'b0, lat);
        check("m7_lat",  32'(lat),    32'd18);
        check("m7_pass", 32'(a_pass), 32'd0);
        check("m7_mv",   32'(a_mv),   32'd1);
        check("m7_midx", 32'(a_midx), 32'd7);

        // Extra reference bit 0: lowest mismatch is 0 but still flagged
        run_a(16'h6E81, 1'b0, lat);
        check("m0_pass", 32'(a_pass), 32'd0);
        check("m0_mv",   32'(a_mv),   32'd1);
        check("m0_midx", 32'(a_midx), 32'd0);

        // start and abort together in IDLE: start wins
        run_a(16'h6E80, 1'b1, lat);
        check("sa_lat",  32'(lat),    32'd18);
        check("sa_pass", 32'(a_pass), 32'd1);

        // Abort on the 5th SCAN cycle
        a_exp   = 16'h6E80;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        check("ab_busy_scan", 32'(a_busy), 32'd1);
        check("ab_cur0",      32'(a_cur),  32'd0);
        check("ab_pass_clr",  32'(a_pass), 32'd0);
        repeat (4) tick();
        check("ab_cur4", 32'(a_cur), 32'd4);
        a_abort = 1'b1;
        tick();
        a_abort = 1'b0;
        check("ab_busy",   32'(a_busy),         32'd0);
        check("ab_pass",   32'(a_pass),         32'd0);
        check("ab_mv",     32'(a_mv),           32'd0);
        check("ab_hi_bits", 32'(a_table[15:5]), 32'd0);
        dones = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (a_done) dones++;
        end
        check("ab_no_done", 32'(dones), 32'd0);

        // start re-pulsed during SCAN is ignored
        a_exp   = 16'h6E80;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            if (i == 4) a_start = 1'b1;
            if (i == 5) a_start = 1'b0;
            tick();
            if (a_done) dones++;
        end
        check("restart_dones", 32'(dones),   32'd1);
        check("restart_table", 32'(a_table), 32'h6E80);

        // Reset mid-scan after minterms 0..8 are captured
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        repeat (9) tick();
        check("pre_rst_table", 32'(a_table), 32'h0080);
        rst_n = 1'b0;
        #1;
        check("mid_rst_table", 32'(a_table), 32'd0);
        check("mid_rst_busy",  32'(a_busy),  32'd0);
        check("mid_rst_cur",   32'(a_cur),   32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        run_a(16'h6E80, 1'b0, lat);
        check("post_rst_lat",   32'(lat),     32'd18);
        check("post_rst_table", 32'(a_table), 32'h6E80);
        check("post_rst_pass",  32'(a_pass),  32'd1);

        // STEP_CYCLES=3: 50-cycle latency, each minterm held three cycles
        b_exp   = 16'h6E80;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        lat = 0;
        while (!b_done && lat < 200) begin
            tick();
            lat++;
            if (lat == 2) check("s3_cur_k2", 32'(b_cur), 32'd0);
            if (lat == 3) check("s3_cur_k3", 32'(b_cur), 32'd1);
            if (lat == 5) check("s3_cur_k5", 32'(b_cur), 32'd1);
            if (lat == 6) check("s3_cur_k6", 32'(b_cur), 32'd2);
        end
        check("s3_lat",   32'(lat),     32'd50);
        check("s3_table", 32'(b_table), 32'h6E80);
        check("s3_pass",  32'(b_pass),  32'd1);
        check("s3_mv",    32'(b_mv),    32'd0);
        check("s3_midx",  32'(b_midx),  32'd0);
`ifdef MINTERM_COUNT_EN
        check("s3_ones",  32'(b_ones),  32'd6);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
